// File: rtl/snake_input_ctrl.sv
// Snake game input stage: conditions the four direction buttons, filters reversals
// and produces the periodic move tick that commits the pending direction.
module snake_input_ctrl #(
    parameter int unsigned MOVE_PERIOD     = 12_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1,
    parameter logic [1:0]  INIT_DIR        = 2'b11
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       Run,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    output logic [1:0] Dir,
    output logic [1:0] PendDir,
    output logic       Started,
    output logic       MoveTick
);
    localparam int TW  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(MOVE_PERIOD - 1);
    localparam logic [DBW-1:0] DB_FULL   = DBW'(DEBOUNCE_CYCLES);

    // Button bit order: 0 = up, 1 = down, 2 = left, 3 = right (also the priority order).
    logic [3:0]     btn;
    logic [3:0]     sync1, sync2;
    logic [DBW-1:0] db_cnt [4];
    logic [3:0]     deb, deb_q, press;
    logic           press_any;
    logic [1:0]     press_dir;
    logic [TW-1:0]  tick_cnt;

    assign btn      = {BtnR, BtnL, BtnD, BtnU};
    assign MoveTick = (tick_cnt == TICK_LAST);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb[i] = (db_cnt[i] == DB_FULL);
        end
        press     = deb & ~deb_q;
        press_any = |press;
        press_dir = 2'b00;
        if (press[0])      press_dir = 2'b00;
        else if (press[1]) press_dir = 2'b01;
        else if (press[2]) press_dir = 2'b10;
        else if (press[3]) press_dir = 2'b11;
    end

    // NOTE: all state, including the per-button counter array, uses non-blocking
    // assignments and is cleared explicitly under reset so a mid-press reset leaves no residue.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb_q    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
            tick_cnt <= '0;
            Dir      <= INIT_DIR;
            PendDir  <= INIT_DIR;
            Started  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (!sync2[i])              db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_FULL) db_cnt[i] <= db_cnt[i] + DBW'(1);
            end

            if (!Run) begin
                // Leaving the run state re-arms: the next run waits for a fresh press.
                Started  <= 1'b0;
                tick_cnt <= '0;
            end else begin
                if (!Started)      tick_cnt <= '0;
                else if (MoveTick) tick_cnt <= '0;
                else               tick_cnt <= tick_cnt + TW'(1);

                if (MoveTick) Dir <= PendDir;

                // Reversal is judged against the committed direction, before any commit this edge.
                if (press_any) begin
                    if (!Started) begin
                        Dir     <= press_dir;
                        PendDir <= press_dir;
                        Started <= 1'b1;
                    end else if (press_dir != (Dir ^ 2'b01)) begin
                        PendDir <= press_dir;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl: MOVE_PERIOD=8 with DEBOUNCE_CYCLES=1 and 4.
module tb_snake_input_ctrl;
    logic       clk = 1'b0;
    logic       rst, run;
    logic       btn_u, btn_d, btn_l, btn_r, btn_d4;
    logic       zero = 1'b0;
    logic [1:0] dir, pend_dir, dir4, pend4;
    logic       started, move_tick, started4, tick4;
    int         checks = 0;
    int         errors = 0;
    int         ticks_seen;

    always #5 clk = ~clk;

    snake_input_ctrl #(.MOVE_PERIOD(8), .DEBOUNCE_CYCLES(1), .INIT_DIR(2'b11)) dut (
        .ClkPort(clk), .Reset(rst), .Run(run),
        .BtnU(btn_u), .BtnD(btn_d), .BtnL(btn_l), .BtnR(btn_r),
        .Dir(dir), .PendDir(pend_dir), .Started(started), .MoveTick(move_tick)
    );

    snake_input_ctrl #(.MOVE_PERIOD(8), .DEBOUNCE_CYCLES(4), .INIT_DIR(2'b11)) dut4 (
        .ClkPort(clk), .Reset(rst), .Run(run),
        .BtnU(zero), .BtnD(btn_d4), .BtnL(zero), .BtnR(zero),
        .Dir(dir4), .PendDir(pend4), .Started(started4), .MoveTick(tick4)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cyc_mon(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (move_tick === 1'b1) ticks_seen++;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single-cycle press; returns just after the edge that accepts it (k+3).
    task automatic press(input logic u, input logic d, input logic l, input logic r);
        btn_u = u; btn_d = d; btn_l = l; btn_r = r;
        cyc(1);
        btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
        cyc(3);
    endtask

    // Waits (bounded) until MoveTick is seen, then steps past the commit edge.
    task automatic sync_tick(input string tag);
        int n = 0;
        while (move_tick !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check(tag, move_tick, 1'b1);
        cyc(1);
    endtask

    initial begin
        rst = 1; run = 1;
        btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0; btn_d4 = 0;
        cyc(2);
        rst = 0;
        check("rst_dir", dir, 2'b11);
        check("rst_pend", pend_dir, 2'b11);
        check("rst_started", started, 1'b0);
        check("rst_tick", move_tick, 1'b0);

        // Idle run: no press, no ticks
        ticks_seen = 0;
        cyc_mon(40);
        check_int("idle_ticks", ticks_seen, 0);
        check("idle_started", started, 1'b0);
        check("idle_dir", dir, 2'b11);

        // 1-cycle R press starts the game at k+3
        btn_r = 1; cyc(1); btn_r = 0;
        cyc(2);
        check("start_k2", started, 1'b0);
        cyc(1);
        check("start_k3", started, 1'b1);
        check("start_dir", dir, 2'b11);
        check("start_tick0", move_tick, 1'b0);
        cyc(6);
        check("tick_s6", move_tick, 1'b0);
        cyc(1);
        check("tick_s7", move_tick, 1'b1);
        cyc(1);
        check("tick_s8", move_tick, 1'b0);
        cyc(7);
        check("tick_s15", move_tick, 1'b1);
        cyc(1);
        check("dir_after_t2", dir, 2'b11);

        // L is the reverse of R: rejected; U accepted and committed on the tick
        press(0, 0, 1, 0);
        check("rev_l_pend", pend_dir, 2'b11);
        sync_tick("t_a");
        check("rev_l_dir", dir, 2'b11);
        press(1, 0, 0, 0);
        check("u_pend", pend_dir, 2'b00);
        check("u_dir_hold", dir, 2'b11);
        sync_tick("t_b");
        check("u_dir", dir, 2'b00);

        // Dir=00: D rejected, R accepted
        press(0, 1, 0, 0);
        check("rev_d_pend", pend_dir, 2'b00);
        sync_tick("t_c");
        press(0, 0, 0, 1);
        check("r_pend", pend_dir, 2'b11);
        sync_tick("t_d");
        check("r_dir", dir, 2'b11);

        // Dir=11: U then L between ticks; L checked against Dir and rejected
        btn_u = 1; cyc(1);
        btn_u = 0; btn_l = 1; cyc(1);
        btn_l = 0; cyc(3);
        check("ul_pend", pend_dir, 2'b00);
        check("ul_dir_hold", dir, 2'b11);
        sync_tick("t_e");
        check("ul_dir", dir, 2'b00);

        // Dir=10 then simultaneous U+L: U wins
        press(0, 0, 1, 0);
        sync_tick("t_f");
        check("l_dir", dir, 2'b10);
        press(1, 0, 1, 0);
        check("prio_pend", pend_dir, 2'b00);
        sync_tick("t_g");
        check("prio_dir", dir, 2'b00);

        // Press on the tick edge: Dir <= old PendDir, reversal judged on old Dir
        btn_l = 1; cyc(1); btn_l = 0;
        cyc(3);
        btn_r = 1; cyc(1); btn_r = 0;
        check("tp_pend_l", pend_dir, 2'b10);
        check("tp_dir_old", dir, 2'b00);
        cyc(2);
        check("tp_tick", move_tick, 1'b1);
        cyc(1);
        check("tp_dir", dir, 2'b10);
        check("tp_pend_r", pend_dir, 2'b11);
        sync_tick("t_h");
        check("tp_dir2", dir, 2'b11);

        // Run falls: ticks stop, presses ignored, state held
        run = 0;
        cyc(1);
        check("stop_started", started, 1'b0);
        check("stop_tick", move_tick, 1'b0);
        ticks_seen = 0;
        press(1, 0, 0, 0);
        cyc_mon(10);
        check("stop_pend", pend_dir, 2'b11);
        check("stop_dir", dir, 2'b11);
        run = 1;
        cyc_mon(12);
        check_int("stop_ticks", ticks_seen, 0);
        check("rerun_started0", started, 1'b0);
        press(0, 1, 0, 0);
        check("rerun_started", started, 1'b1);
        check("rerun_dir", dir, 2'b01);
        check("rerun_pend", pend_dir, 2'b01);
        sync_tick("t_rerun");

        // Reset with a press in flight
        btn_u = 1; cyc(1); btn_u = 0;
        rst = 1; cyc(1); rst = 0;
        cyc(5);
        check("mid_rst_started", started, 1'b0);
        check("mid_rst_dir", dir, 2'b11);
        check("mid_rst_pend", pend_dir, 2'b11);
        check("mid_rst_tick", move_tick, 1'b0);

        // Debounce of 4: 3-cycle press rejected, 4-cycle accepted at k+6
        btn_d4 = 1; cyc(3); btn_d4 = 0;
        cyc(10);
        check("db3_pend", pend4, 2'b11);
        check("db3_started", started4, 1'b0);
        btn_d4 = 1; cyc(4); btn_d4 = 0;
        cyc(2);
        check("db4_k5", pend4, 2'b11);
        cyc(1);
        check("db4_k6_pend", pend4, 2'b01);
        check("db4_k6_dir", dir4, 2'b01);
        check("db4_k6_started", started4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
